mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single shared memory port.
// Round-robin on simultaneous requests; one outstanding memory transaction at a time.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_W-1:0]     i_address,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_W-1:0]     d_address,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_byte_enable,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_byte_enable,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_resp,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t              state_q;
  logic                last_grant_q;   // 1 = data side won the last grant
  logic                op_write_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                i_resp_q;
  logic                d_resp_q;
  logic                busy_q;

  logic                i_req;
  logic                d_req;
  logic                grant_d_side;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the side that did not win last time is served.
  always_comb begin
    grant_d_side = 1'b0;
    if (d_req && (!i_req || !last_grant_q)) begin
      grant_d_side = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      op_write_q    <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_resp_q      <= 1'b0;
      d_resp_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            busy_q       <= 1'b1;
            last_grant_q <= grant_d_side;
            if (grant_d_side) begin
              // A simultaneous read+write request is carried out as a write.
              state_q       <= BUSY_D;
              op_write_q    <= d_write;
              mem_read_q    <= ~d_write;
              mem_write_q   <= d_write;
              mem_address_q <= d_address;
              mem_wdata_q   <= d_write ? d_wdata : '0;
              mem_be_q      <= d_write ? d_byte_enable : '1;
            end else begin
              state_q       <= BUSY_I;
              op_write_q    <= 1'b0;
              mem_read_q    <= 1'b1;
              mem_write_q   <= 1'b0;
              mem_address_q <= i_address;
              mem_wdata_q   <= '0;
              mem_be_q      <= '1;
            end
          end
        end

        BUSY_I, BUSY_D: begin
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (state_q == BUSY_I) begin
              state_q   <= RESP_I;
              i_rdata_q <= mem_rdata;
              i_resp_q  <= 1'b1;
            end else begin
              state_q   <= RESP_D;
              d_rdata_q <= op_write_q ? '0 : mem_rdata;
              d_resp_q  <= 1'b1;
            end
          end
        end

        RESP_I, RESP_D: begin
          state_q  <= IDLE;
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          busy_q   <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          i_resp_q    <= 1'b0;
          d_resp_q    <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign i_rdata         = i_rdata_q;
  assign d_rdata         = d_rdata_q;
  assign i_resp          = i_resp_q;
  assign d_resp          = d_resp_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_byte_enable = '0;
  logic [DW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_byte_enable;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;
  logic          busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [136:0] outs;
    #2 rst = 1'b0;
    #1;
    outs = {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
            i_resp, d_resp, i_rdata, d_rdata, busy};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_async: got %h want 0", outs); end
    tick; tick;
    outs = {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
            i_resp, d_resp, i_rdata, d_rdata, busy};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_held: got %h want 0", outs); end
    rst = 1'b1;
    tick;
    outs = {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
            i_resp, d_resp, i_rdata, d_rdata, busy};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_after: got %h want 0", outs); end
    $display("txn reset: outputs=%h", outs);
  endtask

  task automatic test_i_read;
    i_read = 1'b1; i_address = 32'h60;
    tick;
    for (int c = 0; c < 2; c++) begin
      total++;
      if ({mem_read, mem_write, mem_address, mem_byte_enable, busy, i_resp} !==
          {1'b1, 1'b0, 32'h60, 4'hF, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL i_read_busy c=%0d: got rd=%b wr=%b a=%h be=%h busy=%b resp=%b want rd=1 wr=0 a=60 be=f busy=1 resp=0",
                 c, mem_read, mem_write, mem_address, mem_byte_enable, busy, i_resp);
      end
      if (c == 1) begin mem_resp = 1'b1; mem_rdata = 32'h13; end
      tick;
    end
    mem_resp = 1'b0; mem_rdata = '0;
    total++;
    if ({i_resp, d_resp, i_rdata, mem_read, mem_write} !== {1'b1, 1'b0, 32'h13, 2'b00}) begin
      bad++;
      $display("FAIL i_read_resp: got iresp=%b dresp=%b rdata=%h rd=%b wr=%b want 1 0 00000013 0 0",
               i_resp, d_resp, i_rdata, mem_read, mem_write);
    end
    i_read = 1'b0;
    tick;
    total++;
    if ({i_resp, busy, i_rdata} !== {1'b0, 1'b0, 32'h13}) begin
      bad++;
      $display("FAIL i_read_after: got iresp=%b busy=%b rdata=%h want 0 0 00000013", i_resp, busy, i_rdata);
    end
    $display("txn i_read: addr=60 rdata=%h", i_rdata);
  endtask

  task automatic test_d_write;
    d_write = 1'b1; d_address = 32'h104; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0001;
    tick;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, busy} !==
          {1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 4'b0001, 1'b1}) begin
        bad++;
        $display("FAIL d_write_busy c=%0d: got rd=%b wr=%b a=%h wd=%h be=%h busy=%b want 0 1 104 deadbeef 1 1",
                 c, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, busy);
      end
      if (c == 2) begin mem_resp = 1'b1; mem_rdata = 32'hFFFFFFFF; end
      tick;
    end
    mem_resp = 1'b0;
    total++;
    if ({d_resp, i_resp, d_rdata, mem_write} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL d_write_resp: got dresp=%b iresp=%b rdata=%h wr=%b want 1 0 0 0", d_resp, i_resp, d_rdata, mem_write);
    end
    d_write = 1'b0;
    tick;
    total++;
    if ({d_resp, busy} !== 2'b00) begin
      bad++; $display("FAIL d_write_after: got dresp=%b busy=%b want 0 0", d_resp, busy);
    end
    $display("txn d_write: addr=104 wdata=deadbeef be=1");
  endtask

  task automatic test_addr_hold;
    d_read = 1'b1; d_address = 32'h200;
    tick;
    d_address = 32'h300; d_write = 1'b1; d_byte_enable = 4'hA; d_wdata = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({mem_read, mem_write, mem_address, mem_byte_enable} !== {1'b1, 1'b0, 32'h200, 4'hF}) begin
        bad++;
        $display("FAIL addr_hold c=%0d: got rd=%b wr=%b a=%h be=%h want 1 0 200 f",
                 c, mem_read, mem_write, mem_address, mem_byte_enable);
      end
      if (c == 2) begin mem_resp = 1'b1; mem_rdata = 32'hCAFE0001; end
      tick;
    end
    mem_resp = 1'b0;
    total++;
    if ({d_resp, d_rdata} !== {1'b1, 32'hCAFE0001}) begin
      bad++; $display("FAIL addr_hold_resp: got dresp=%b rdata=%h want 1 cafe0001", d_resp, d_rdata);
    end
    d_read = 1'b0; d_write = 1'b0;
    tick;
    $display("txn addr_hold: addr stayed 200 rdata=%h", d_rdata);
  endtask

  task automatic test_idle_resp;
    mem_resp = 1'b1; mem_rdata = 32'h55555555;
    tick; tick;
    mem_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if ({busy, i_resp, d_resp, mem_read, mem_write, i_rdata, d_rdata} !==
          {5'b0, 32'h13, 32'hCAFE0001}) begin
        bad++;
        $display("FAIL idle_resp c=%0d: got busy=%b iresp=%b dresp=%b rd=%b wr=%b ird=%h drd=%h want 0 0 0 0 0 13 cafe0001",
                 c, busy, i_resp, d_resp, mem_read, mem_write, i_rdata, d_rdata);
      end
      tick;
    end
    $display("txn idle_resp: ignored");
  endtask

  task automatic test_round_robin;
    logic last_m;
    logic side;
    rst = 1'b0; tick; rst = 1'b1; tick;
    last_m = 1'b1;
    i_read = 1'b1; i_address = 32'h1000;
    d_read = 1'b1; d_address = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      side = ~last_m;
      last_m = side;
      tick;
      total++;
      if ({mem_read, mem_address, busy} !== {1'b1, (side ? 32'h2000 : 32'h1000), 1'b1}) begin
        bad++;
        $display("FAIL rr_grant k=%0d: got rd=%b a=%h busy=%b want 1 %h 1",
                 k, mem_read, mem_address, busy, side ? 32'h2000 : 32'h1000);
      end
      repeat ($urandom_range(0, 2)) tick;
      mem_resp = 1'b1; mem_rdata = 32'hA0 + k;
      tick;
      mem_resp = 1'b0;
      total++;
      if ({i_resp, d_resp} !== {~side, side}) begin
        bad++;
        $display("FAIL rr_resp k=%0d: got iresp=%b dresp=%b want %b %b", k, i_resp, d_resp, ~side, side);
      end
      $display("txn rr k=%0d: grant=%s", k, side ? "D" : "I");
      tick;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle k=%0d: got busy=%b want 0", k, busy); end
    end
    i_read = 1'b0; d_read = 1'b0;
    tick;
  endtask

  task automatic test_random;
    logic          last_m;
    logic [DW-1:0] i_rd_m;
    logic [DW-1:0] d_rd_m;
    logic          i_on, d_on, gd, is_wr;
    int            sel, dop, delay;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, rdata;
    logic [BW-1:0] exp_be;
    rst = 1'b0; tick; rst = 1'b1; tick;
    last_m = 1'b1; i_rd_m = '0; d_rd_m = '0;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(1, 3);
      dop = $urandom_range(0, 2);
      i_on = sel[0]; d_on = sel[1];
      i_read = i_on; i_address = $urandom;
      d_read = d_on && (dop != 1); d_write = d_on && (dop != 0);
      d_address = $urandom; d_wdata = $urandom; d_byte_enable = 4'($urandom_range(0, 15));
      gd = (i_on && d_on) ? ~last_m : d_on;
      last_m = gd;
      is_wr = gd && (dop != 0);
      exp_addr = gd ? d_address : i_address;
      exp_be = is_wr ? d_byte_enable : 4'hF;
      exp_wd = d_wdata;
      delay = $urandom_range(0, 3);
      rdata = $urandom;
      tick;
      for (int c = 0; c <= delay; c++) begin
        total++;
        if ({mem_read, mem_write, mem_address, mem_byte_enable, busy, i_resp, d_resp} !==
            {~is_wr, is_wr, exp_addr, exp_be, 1'b1, 2'b00}) begin
          bad++;
          $display("FAIL rnd_busy n=%0d c=%0d: got rd=%b wr=%b a=%h be=%h busy=%b resp=%b%b want %b %b %h %h 1 00",
                   n, c, mem_read, mem_write, mem_address, mem_byte_enable, busy, i_resp, d_resp,
                   ~is_wr, is_wr, exp_addr, exp_be);
        end
        if (is_wr) begin
          total++;
          if (mem_wdata !== exp_wd) begin
            bad++; $display("FAIL rnd_wdata n=%0d c=%0d: got %h want %h", n, c, mem_wdata, exp_wd);
          end
        end
        i_address = $urandom; d_address = $urandom; d_wdata = $urandom;
        d_byte_enable = 4'($urandom_range(0, 15));
        mem_resp = (c == delay);
        mem_rdata = (c == delay) ? rdata : $urandom;
        tick;
      end
      if (gd) d_rd_m = is_wr ? '0 : rdata;
      else    i_rd_m = rdata;
      total++;
      if ({i_resp, d_resp, i_rdata, d_rdata, mem_read, mem_write, busy} !==
          {~gd, gd, i_rd_m, d_rd_m, 2'b00, 1'b1}) begin
        bad++;
        $display("FAIL rnd_resp n=%0d: got resp=%b%b ird=%h drd=%h rd=%b wr=%b busy=%b want %b%b %h %h 0 0 1",
                 n, i_resp, d_resp, i_rdata, d_rdata, mem_read, mem_write, busy, ~gd, gd, i_rd_m, d_rd_m);
      end
      $display("txn rnd n=%0d: side=%s op=%s addr=%h delay=%0d", n, gd ? "D" : "I", is_wr ? "W" : "R", exp_addr, delay);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      mem_resp = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      tick;
      total++;
      if ({i_resp, d_resp, busy, i_rdata, d_rdata} !== {3'b000, i_rd_m, d_rd_m}) begin
        bad++;
        $display("FAIL rnd_idle n=%0d: got resp=%b%b busy=%b ird=%h drd=%h want 00 0 %h %h",
                 n, i_resp, d_resp, busy, i_rdata, d_rdata, i_rd_m, d_rd_m);
      end
      mem_resp = 1'($urandom_range(0, 1));
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic [136:0] outs;
    i_read = 1'b1; i_address = 32'h44;
    tick; tick;
    total++;
    if ({busy, mem_read} !== 2'b11) begin
      bad++; $display("FAIL abort_busy: got busy=%b rd=%b want 1 1", busy, mem_read);
    end
    #2 rst = 1'b0; i_read = 1'b0;
    #1;
    outs = {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
            i_resp, d_resp, i_rdata, d_rdata, busy};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL abort_async: got %h want 0", outs); end
    tick;
    rst = 1'b1;
    tick;
    mem_resp = 1'b1; mem_rdata = 32'h77;
    tick;
    mem_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      outs = {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
              i_resp, d_resp, i_rdata, d_rdata, busy};
      total++;
      if (outs !== '0) begin bad++; $display("FAIL abort_late_resp c=%0d: got %h want 0", c, outs); end
      tick;
    end
    $display("txn reset_abort: outputs=%h", outs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_addr_hold();
    test_idle_resp();
    test_round_robin();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
